// File: rtl/axi_range_reader_if.sv
// AXI read-channel (AR/R) plus address-tagged output stream used by axi_range_reader.
// master = the range reader; slave = the memory and the stream consumer.
interface axi_range_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_size;
  logic              ar_valid;
  logic              ar_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output ar_addr, ar_size, ar_valid, r_ready, out_data, out_addr, out_last, out_valid,
    input  ar_ready, r_data, r_resp, r_valid, out_ready
  );

  modport slave (
    input  ar_addr, ar_size, ar_valid, r_ready, out_data, out_addr, out_last, out_valid,
    output ar_ready, r_data, r_resp, r_valid, out_ready
  );
endinterface

// File: rtl/axi_range_reader.sv
// AXI read master sweeping an inclusive address range one beat at a time and streaming each
// returned word, tagged with its address, to a valid/ready consumer.
module axi_range_reader #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_begin_i,
  input  logic [ADDR_W-1:0]   addr_end_i,
  input  logic [1:0]          size_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [ADDR_W-1:0]   err_addr_o,
  axi_range_reader_if.master  bus
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StPush, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                ar_valid_q, ar_valid_d;
  logic                r_ready_q, r_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [ADDR_W-1:0]   in_mask;
  logic [ADDR_W-1:0]   step;
  logic                cfg_bad;

  // Alignment checks on both ends make the sweep land exactly on addr_end, so cur never wraps.
  always_comb begin
    in_mask = (ADDR_W'(1) << size_i) - ADDR_W'(1);
    step    = ADDR_W'(1) << size_q;
    cfg_bad = (size_i == 2'd0) || (addr_begin_i > addr_end_i) ||
              ((addr_begin_i & in_mask) != '0) || ((addr_end_i & in_mask) != '0) ||
              (((addr_end_i - addr_begin_i) & in_mask) != '0);
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    size_d      = size_q;
    data_d      = data_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_addr_d  = err_addr_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          cur_d      = addr_begin_i;
          end_d      = addr_end_i;
          size_d     = size_i;
          error_d    = 1'b0;
          err_addr_d = '0;
          if (cfg_bad) begin
            error_d    = 1'b1;
            err_addr_d = addr_begin_i;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = StDone;
          end else begin
            busy_d     = 1'b1;
            ar_valid_d = 1'b1;
            state_d    = StAddr;
          end
        end
      end
      StAddr: begin
        if (bus.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = StData;
        end
      end
      StData: begin
        if (bus.r_valid) begin
          r_ready_d = 1'b0;
          if (bus.r_resp != 2'd0) begin
            error_d    = 1'b1;
            err_addr_d = cur_q;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = StDone;
          end else begin
            data_d      = bus.r_data;
            last_d      = (cur_q == end_q);
            out_valid_d = 1'b1;
            state_d     = StPush;
          end
        end
      end
      StPush: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end else begin
            cur_d      = cur_q + step;
            ar_valid_d = 1'b1;
            state_d    = StAddr;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      end_q       <= '0;
      size_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      size_q      <= size_d;
      data_q      <= data_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign err_addr_o    = err_addr_q;
  assign bus.ar_addr   = cur_q;
  assign bus.ar_size   = {1'b0, size_q};
  assign bus.ar_valid  = ar_valid_q;
  assign bus.r_ready   = r_ready_q;
  assign bus.out_data  = data_q;
  assign bus.out_addr  = cur_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_axi_range_reader.sv
// Directed bench for axi_range_reader: behavioural AXI slave, stream sink with optional
// backpressure, and a beat log compared against expected sweeps.
module tb_axi_range_reader;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start;
  logic [AW-1:0] begin_a, end_a;
  logic [1:0]    size;
  logic          busy, done, error;
  logic [AW-1:0] err_addr;

  axi_range_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_range_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .addr_begin_i(begin_a),
    .addr_end_i  (end_a),
    .size_i      (size),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .err_addr_o  (err_addr),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit bp = 1'b0;
  bit bad_en = 1'b0;
  logic [AW-1:0] bad_addr = '0;

  // Written only by the posedge monitor.
  int            done_cnt = 0;
  int            ar_hs_cnt = 0;
  int            r_hs_cnt = 0;
  logic [AW-1:0] ar_hs_addr = '0;
  logic [2:0]    last_ar_size = '0;
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  logic          q_last[$];
  bit            prev_done = 1'b0;
  bit            prev_ar_stall = 1'b0;
  bit            prev_out_stall = 1'b0;
  logic [AW-1:0] snap_ar, snap_oa;
  logic [DW-1:0] snap_od;
  logic          snap_ol;

  // Written only by the negedge slave.
  int            ar_seen = 0;
  int            r_seen = 0;
  bit            pending = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      prev_done      = 1'b0;
      prev_ar_stall  = 1'b0;
      prev_out_stall = 1'b0;
    end else begin
      if (prev_ar_stall) chk("ar_stable", {bus.ar_valid, bus.ar_addr}, {1'b1, snap_ar});
      prev_ar_stall = bus.ar_valid && !bus.ar_ready;
      snap_ar       = bus.ar_addr;
      if (prev_out_stall) begin
        chk("out_stable_v", bus.out_valid, 1'b1);
        chk("out_stable_d", bus.out_data, snap_od);
        chk("out_stable_a", {bus.out_last, bus.out_addr}, {snap_ol, snap_oa});
      end
      prev_out_stall = bus.out_valid && !bus.out_ready;
      snap_od = bus.out_data;
      snap_oa = bus.out_addr;
      snap_ol = bus.out_last;
      if (bus.ar_valid && bus.ar_ready) begin
        ar_hs_addr   = bus.ar_addr;
        last_ar_size = bus.ar_size;
        ar_hs_cnt++;
      end
      if (bus.r_valid && bus.r_ready) r_hs_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        q_addr.push_back(bus.out_addr);
        q_data.push_back(bus.out_data);
        q_last.push_back(bus.out_last);
      end
      if (done) begin
        chk("done_width", prev_done, 1'b0);
        done_cnt++;
      end
      prev_done = done;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pending      = 1'b0;
      ar_seen      = ar_hs_cnt;
      r_seen       = r_hs_cnt;
      bus.r_valid  = 1'b0;
      bus.r_data   = '0;
      bus.r_resp   = '0;
      bus.ar_ready = 1'b0;
    end else begin
      if (r_seen != r_hs_cnt) begin
        r_seen      = r_hs_cnt;
        bus.r_valid = 1'b0;
        pending     = 1'b0;
      end
      if (ar_seen != ar_hs_cnt) begin
        ar_seen   = ar_hs_cnt;
        pending   = 1'b1;
        pend_addr = ar_hs_addr;
      end
      if (pending && !bus.r_valid && (!bp || $urandom_range(0, 1) == 1)) begin
        bus.r_valid = 1'b1;
        bus.r_data  = mem_word(pend_addr);
        bus.r_resp  = (bad_en && pend_addr == bad_addr) ? 2'd2 : 2'd0;
      end
      bus.ar_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic start_sweep(input string tag, input logic [AW-1:0] b, input logic [AW-1:0] e,
                             input logic [1:0] s, input bit good);
    @(negedge clk);
    begin_a = b;
    end_a   = e;
    size    = s;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (good) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_err_clr"}, error, 1'b0);
    end else begin
      chk({tag, "_done_next"}, {busy, done, error}, 3'b011);
    end
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic check_beats(input string tag, input int base, input logic [AW-1:0] b,
                             input logic [AW-1:0] e, input int s, input int n);
    logic [AW-1:0] a;
    chk({tag, "_beats"}, 64'(q_addr.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < q_addr.size()) begin
        a = b + AW'(i << s);
        chk({tag, "_addr"}, q_addr[base+i], a);
        chk({tag, "_data"}, q_data[base+i], mem_word(a));
        chk({tag, "_last"}, q_last[base+i], a == e);
      end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy, done, error, err_addr, bus.ar_valid, bus.r_ready, bus.out_valid,
                        bus.out_last, bus.ar_size}, '0);
    chk({tag, "_addr"}, {bus.ar_addr, bus.out_addr}, '0);
    chk({tag, "_data"}, bus.out_data, '0);
  endtask

  initial begin
    int base, d0, a0, n;
    start   = 1'b0;
    begin_a = '0;
    end_a   = '0;
    size    = '0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;

    // 1: basic 4-byte sweep
    base = q_addr.size(); d0 = done_cnt;
    start_sweep("t1", 32'h10, 32'h20, 2'd2, 1'b1);
    wait_done("t1", d0, 200);
    check_beats("t1", base, 32'h10, 32'h20, 2, 5);
    chk("t1_error", error, 1'b0);

    // 2: single 8-byte beat
    base = q_addr.size(); d0 = done_cnt;
    start_sweep("t2", 32'h40, 32'h40, 2'd3, 1'b1);
    wait_done("t2", d0, 100);
    check_beats("t2", base, 32'h40, 32'h40, 3, 1);
    chk("t2_arsize", last_ar_size, 3'd3);

    // 3: random backpressure, 2-byte beats
    bp = 1'b1;
    base = q_addr.size(); d0 = done_cnt;
    start_sweep("t3", 32'h0, 32'hE, 2'd1, 1'b1);
    wait_done("t3", d0, 3000);
    check_beats("t3", base, 32'h0, 32'hE, 1, 8);
    chk("t3_arsize", last_ar_size, 3'd1);
    bp = 1'b0;

    // 4: error response mid-sweep
    bad_en = 1'b1; bad_addr = 32'h18;
    base = q_addr.size(); d0 = done_cnt;
    start_sweep("t4", 32'h10, 32'h20, 2'd2, 1'b1);
    wait_done("t4", d0, 200);
    check_beats("t4", base, 32'h10, 32'h20, 2, 2);
    chk("t4_error", error, 1'b1);
    chk("t4_err_addr", err_addr, 32'h18);
    bad_en = 1'b0;

    // 5: config errors, then a good start clears error_o
    a0 = ar_hs_cnt; d0 = done_cnt;
    start_sweep("t5a", 32'h12, 32'h20, 2'd2, 1'b0);
    wait_done("t5a", d0, 20);
    chk("t5a_err_addr", err_addr, 32'h12);
    d0 = done_cnt;
    start_sweep("t5b", 32'h20, 32'h10, 2'd2, 1'b0);
    wait_done("t5b", d0, 20);
    chk("t5b_err_addr", err_addr, 32'h20);
    d0 = done_cnt;
    start_sweep("t5c", 32'h10, 32'h20, 2'd0, 1'b0);
    wait_done("t5c", d0, 20);
    chk("t5_no_ar", 64'(ar_hs_cnt - a0), 64'd0);
    base = q_addr.size(); d0 = done_cnt;
    start_sweep("t5d", 32'h0, 32'h4, 2'd2, 1'b1);
    wait_done("t5d", d0, 100);
    check_beats("t5d", base, 32'h0, 32'h4, 2, 2);
    chk("t5d_error", error, 1'b0);

    // 6: reset while waiting for read data, then a clean sweep
    start_sweep("t6a", 32'h10, 32'h20, 2'd2, 1'b1);
    n = 0;
    while (!bus.r_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_data", bus.r_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("t6_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = q_addr.size(); d0 = done_cnt;
    start_sweep("t6b", 32'h10, 32'h20, 2'd2, 1'b1);
    wait_done("t6b", d0, 200);
    check_beats("t6b", base, 32'h10, 32'h20, 2, 5);
    chk("t6_error", error, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
